// File: rtl/mss_gpio_irq_conditioner.sv
//------------------------------------------------------------------------------
// Module  : mss_gpio_irq_conditioner
// Brief   : N-channel GPIO synchroniser/debouncer with edge/level interrupt
//           detection, sticky pending bits and one masked, registered IRQ line.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mss_gpio_irq_conditioner #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic                FAB_CCC_GL0,
  input  logic                FAB_RESET_N,
  input  logic [N_CH-1:0]     GPIO_IN,
  input  logic [2*N_CH-1:0]   IRQ_MODE,
  input  logic [N_CH-1:0]     IRQ_EN,
  input  logic [N_CH-1:0]     IRQ_CLR,
  output logic [N_CH-1:0]     GPIO_DB,
  output logic [N_CH-1:0]     IRQ_PEND,
  output logic                IRQ_OUT
);

  localparam int                c_cnt_w    = $clog2(DEB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  localparam logic [1:0] c_mode_rise  = 2'b00;
  localparam logic [1:0] c_mode_fall  = 2'b01;
  localparam logic [1:0] c_mode_both  = 2'b10;
  localparam logic [1:0] c_mode_level = 2'b11;

  logic [N_CH-1:0] r_db;
  logic [N_CH-1:0] r_pend;
  logic            r_irq_out;
  logic [N_CH-1:0] w_db_nxt;
  logic [N_CH-1:0] w_evt;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_cnt_w-1:0]     r_cnt;
      logic                   w_s;
      logic                   w_acc;

      always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], GPIO_IN[g]};
        end
      end

      assign w_s   = r_sync[SYNC_STAGES-1];
      assign w_acc = (w_s != r_db[g]) && (r_cnt == c_cnt_last);

      // Counter only runs while the synchronised level disagrees with GPIO_DB,
      // so a return to the old level restarts qualification from zero.
      always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
          r_cnt <= '0;
        end else if ((w_s == r_db[g]) || w_acc) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db_nxt[g] = w_acc ? w_s : r_db[g];

      // Level mode looks at the value GPIO_DB takes this edge, so the pending
      // bit rises together with GPIO_DB and a clear only sticks once it falls.
      always_comb begin
        w_evt[g] = 1'b0;
        case (IRQ_MODE[2*g+1 -: 2])
          c_mode_rise:  w_evt[g] = w_acc &  w_s;
          c_mode_fall:  w_evt[g] = w_acc & ~w_s;
          c_mode_both:  w_evt[g] = w_acc;
          c_mode_level: w_evt[g] = w_db_nxt[g];
          default:      w_evt[g] = 1'b0;
        endcase
      end
    end
  endgenerate

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      r_db      <= '0;
      r_pend    <= '0;
      r_irq_out <= 1'b0;
    end else begin
      r_db      <= w_db_nxt;
      r_pend    <= w_evt | (r_pend & ~IRQ_CLR);
      r_irq_out <= |(r_pend & IRQ_EN);
    end
  end

  assign GPIO_DB  = r_db;
  assign IRQ_PEND = r_pend;
  assign IRQ_OUT  = r_irq_out;

endmodule

`default_nettype wire

// File: tb/tb_mss_gpio_irq_conditioner.sv
//------------------------------------------------------------------------------
// Module  : tb_mss_gpio_irq_conditioner
// Brief   : Directed self-checking bench for mss_gpio_irq_conditioner.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mss_gpio_irq_conditioner;

  logic        clk;
  logic        rst_n;
  logic [7:0]  gpio_in;
  logic [15:0] irq_mode;
  logic [7:0]  irq_en;
  logic [7:0]  irq_clr;
  logic [7:0]  gpio_db;
  logic [7:0]  irq_pend;
  logic        irq_out;

  int n_total = 0;
  int n_fail  = 0;

  mss_gpio_irq_conditioner #(
    .N_CH       (8),
    .SYNC_STAGES(2),
    .DEB_CYCLES (16)
  ) dut (
    .FAB_CCC_GL0(clk),
    .FAB_RESET_N(rst_n),
    .GPIO_IN    (gpio_in),
    .IRQ_MODE   (irq_mode),
    .IRQ_EN     (irq_en),
    .IRQ_CLR    (irq_clr),
    .GPIO_DB    (gpio_db),
    .IRQ_PEND   (irq_pend),
    .IRQ_OUT    (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    gpio_in  = '0;
    // ch2 both edges, ch3 level-high, everything else rising edge
    irq_mode = 16'h00E0;
    irq_en   = '0;
    irq_clr  = '0;
    tick(3);
    chk("reset_db",   32'(gpio_db),  32'h0);
    chk("reset_pend", 32'(irq_pend), 32'h0);
    chk("reset_out",  32'(irq_out),  32'h0);
    rst_n = 1'b1;
    tick(4);

    // 1: rising edge on ch0, 18-edge latency, IRQ_OUT one edge later, clear
    irq_en     = 8'h01;
    gpio_in[0] = 1'b1;
    tick(17);
    chk("t1_db_e17",   32'(gpio_db[0]),  32'h0);
    tick(1);
    chk("t1_db_e18",   32'(gpio_db[0]),  32'h1);
    chk("t1_pend_e18", 32'(irq_pend),    32'h01);
    chk("t1_out_e18",  32'(irq_out),     32'h0);
    tick(1);
    chk("t1_out_e19",  32'(irq_out),     32'h1);
    irq_clr = 8'h01;
    tick(1);
    irq_clr = 8'h00;
    chk("t1_pend_clr", 32'(irq_pend[0]), 32'h0);
    chk("t1_out_lag",  32'(irq_out),     32'h1);
    tick(1);
    chk("t1_out_low",  32'(irq_out),     32'h0);

    // 2: glitches of 10 and 15 cycles on ch1 never qualify
    gpio_in[1] = 1'b1;
    tick(10);
    gpio_in[1] = 1'b0;
    tick(20);
    gpio_in[1] = 1'b1;
    tick(15);
    gpio_in[1] = 1'b0;
    tick(25);
    chk("t2_db",   32'(gpio_db[1]),  32'h0);
    chk("t2_pend", 32'(irq_pend[1]), 32'h0);

    // 3: ch2 both-edge mode with interrupt masked, then unmasked
    irq_en     = 8'h00;
    gpio_in[2] = 1'b1;
    tick(20);
    chk("t3_db_rise",   32'(gpio_db[2]),  32'h1);
    chk("t3_pend_rise", 32'(irq_pend[2]), 32'h1);
    irq_clr = 8'h04;
    tick(1);
    irq_clr = 8'h00;
    chk("t3_pend_clr",  32'(irq_pend[2]), 32'h0);
    gpio_in[2] = 1'b0;
    tick(20);
    chk("t3_db_fall",   32'(gpio_db[2]),  32'h0);
    chk("t3_pend_fall", 32'(irq_pend[2]), 32'h1);
    chk("t3_out_mask",  32'(irq_out),     32'h0);
    irq_en = 8'h04;
    tick(1);
    chk("t3_out_en",    32'(irq_out),     32'h1);
    irq_clr = 8'h04;
    tick(1);
    irq_clr = 8'h00;
    tick(1);
    chk("t3_out_low",   32'(irq_out),     32'h0);

    // 4: ch3 level-high mode resists clear until the pin drops
    irq_en     = 8'h00;
    gpio_in[3] = 1'b1;
    tick(18);
    chk("t4_db",        32'(gpio_db[3]),  32'h1);
    chk("t4_pend",      32'(irq_pend[3]), 32'h1);
    irq_clr = 8'h08;
    tick(1);
    irq_clr = 8'h00;
    chk("t4_pend_hold", 32'(irq_pend[3]), 32'h1);
    gpio_in[3] = 1'b0;
    tick(18);
    chk("t4_db_low",    32'(gpio_db[3]),  32'h0);
    tick(1);
    irq_clr = 8'h08;
    tick(1);
    irq_clr = 8'h00;
    chk("t4_pend_clr",  32'(irq_pend[3]), 32'h0);

    // 5: clear coincides with the accept edge of a new rising event on ch0
    gpio_in[0] = 1'b0;
    tick(20);
    chk("t5_fall_nopend", 32'(irq_pend[0]), 32'h0);
    gpio_in[0] = 1'b1;
    tick(17);
    irq_clr = 8'h01;
    tick(1);
    irq_clr = 8'h00;
    chk("t5_db",        32'(gpio_db[0]),  32'h1);
    chk("t5_set_wins",  32'(irq_pend[0]), 32'h1);

    // 6: async reset in the middle of ch4 debounce, release with pin high
    irq_en     = 8'h10;
    gpio_in[4] = 1'b1;
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_db",   32'(gpio_db),  32'h0);
    chk("t6_rst_pend", 32'(irq_pend), 32'h0);
    chk("t6_rst_out",  32'(irq_out),  32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(17);
    chk("t6_db_e17",   32'(gpio_db[4]),         32'h0);
    tick(1);
    chk("t6_db_e18",   32'(gpio_db[4]),         32'h1);
    chk("t6_pend_e18", 32'(irq_pend & 8'h10),   32'h10);
    tick(1);
    chk("t6_out_e19",  32'(irq_out),            32'h1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

`default_nettype wire
